envelope_vca: RTL and testbench

- Three-voice, time-multiplexed ADSR envelope generator with built-in VCA multiplier, in the synth voice datapath after the oscillator/waveform stage.
- Each start_i pulse is one sample tick for the selected voice:
  - advance that voice's 8-bit envelope;
  - multiply the voice's signed 10-bit sample by the envelope on an internal sequential shift-add multiplier;
  - present a 40-bit signed product.

---
 rtl/envelope_vca.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_envelope_vca.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/envelope_vca.sv
// Three-voice time-multiplexed ADSR envelope generator with a shift-add VCA multiplier.
// Each accepted start advances one voice's envelope and scales its sample by it.
module envelope_vca (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [9:0]  voice_i,
  input  logic [1:0]  voice_idx_i,
  input  logic        gate_i,
  input  logic [3:0]  attack_i,
  input  logic [3:0]  decay_i,
  input  logic [3:0]  sustain_i,
  input  logic [3:0]  release_i,
  output logic        ready_o,
  output logic [39:0] prod_o
);

  localparam int unsigned NV  = 3;
  localparam int unsigned EW  = 8;
  localparam int unsigned SW  = 10;
  localparam int unsigned AW  = 24;
  localparam int unsigned BW  = 16;
  localparam int unsigned PW  = 40;
  localparam int unsigned CW  = 16;
  localparam int unsigned MCW = 5;

  typedef enum logic [1:0] {C_IDLE, C_UPDATE, C_MSTART, C_MWAIT} ctrl_e;
  typedef enum logic [1:0] {E_RELEASE, E_ATTACK, E_DECAY} env_e;

  ctrl_e            ctrl_q, ctrl_d;
  logic             ready_q, ready_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [SW-1:0]    smp_q, smp_d;
  logic [1:0]       idx_q, idx_d;
  logic             gate_q, gate_d;
  logic [3:0]       atk_q, atk_d, dec_q, dec_d, sus_q, sus_d, rel_q, rel_d;

  logic [EW-1:0]    env_q [NV];
  logic [EW-1:0]    env_d [NV];
  env_e             est_q [NV];
  env_e             est_d [NV];
  logic             pg_q  [NV];
  logic             pg_d  [NV];
  logic [CW-1:0]    cnt_q [NV];
  logic [CW-1:0]    cnt_d [NV];

  logic [PW-1:0]    ma_q, ma_d;
  logic [BW-1:0]    mb_q, mb_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [MCW-1:0]   mcnt_q, mcnt_d;

  logic             accept_c, upd_c, mload_c, mstep_c, mdone_c;
  logic             mlast_c;

  // Ticks per envelope step for a 4-bit rate index
  function automatic logic [CW-1:0] rate_p(input logic [3:0] r);
    logic [CW-1:0] p;
    case (r)
      4'd0:    p = 16'd1;
      4'd1:    p = 16'd2;
      4'd2:    p = 16'd3;
      4'd3:    p = 16'd4;
      4'd4:    p = 16'd6;
      4'd5:    p = 16'd9;
      4'd6:    p = 16'd11;
      4'd7:    p = 16'd13;
      4'd8:    p = 16'd16;
      4'd9:    p = 16'd39;
      4'd10:   p = 16'd78;
      4'd11:   p = 16'd125;
      4'd12:   p = 16'd156;
      4'd13:   p = 16'd469;
      4'd14:   p = 16'd781;
      default: p = 16'd1250;
    endcase
    return p;
  endfunction

  assign mlast_c = (mcnt_q == MCW'(BW));

  // Controller state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ctrl_q <= C_IDLE;
    else         ctrl_q <= ctrl_d;
  end

  // Controller next state
  always_comb begin
    ctrl_d = ctrl_q;
    case (ctrl_q)
      C_IDLE:   if (start_i && ready_q && (voice_idx_i != 2'd3)) ctrl_d = C_UPDATE;
      C_UPDATE: ctrl_d = C_MSTART;
      C_MSTART: ctrl_d = C_MWAIT;
      C_MWAIT:  if (mlast_c) ctrl_d = C_IDLE;
      default:  ctrl_d = C_IDLE;
    endcase
  end

  // Controller strobes
  always_comb begin
    accept_c = 1'b0;
    upd_c    = 1'b0;
    mload_c  = 1'b0;
    mstep_c  = 1'b0;
    mdone_c  = 1'b0;
    case (ctrl_q)
      C_IDLE:   accept_c = start_i && ready_q && (voice_idx_i != 2'd3);
      C_UPDATE: upd_c    = 1'b1;
      C_MSTART: mload_c  = 1'b1;
      C_MWAIT: begin
        mdone_c = mlast_c;
        mstep_c = !mlast_c;
      end
      default: ;
    endcase
  end

  // Envelope step for the captured voice
  logic [EW-1:0] e_cur, e_new;
  env_e          s_mid, s_new;
  logic [CW-1:0] c_mid, c_new, per;
  logic          pg_cur, step;

  always_comb begin
    e_cur  = env_q[0];
    s_mid  = est_q[0];
    c_mid  = cnt_q[0];
    pg_cur = pg_q[0];
    for (int unsigned v = 0; v < NV; v++) begin
      if (idx_q == 2'(v)) begin
        e_cur  = env_q[v];
        s_mid  = est_q[v];
        c_mid  = cnt_q[v];
        pg_cur = pg_q[v];
      end
    end
    if (gate_q && !pg_cur) begin
      s_mid = E_ATTACK;
      c_mid = '0;
    end else if (!gate_q && pg_cur) begin
      s_mid = E_RELEASE;
      c_mid = '0;
    end
    case (s_mid)
      E_ATTACK: per = rate_p(atk_q);
      E_DECAY:  per = CW'(rate_p(dec_q) * 16'd3);
      default:  per = CW'(rate_p(rel_q) * 16'd3);
    endcase
    step  = (c_mid >= (per - 16'd1));
    c_new = step ? '0 : (c_mid + 16'd1);
    e_new = e_cur;
    s_new = s_mid;
    if (step) begin
      case (s_mid)
        E_ATTACK: if (e_cur != 8'hFF) e_new = e_cur + 8'd1;
        E_DECAY:  if (e_cur > {sus_q, sus_q}) e_new = e_cur - 8'd1;
        default:  if (e_cur != 8'h00) e_new = e_cur - 8'd1;
      endcase
    end
    if ((s_mid == E_ATTACK) && (e_new == 8'hFF)) s_new = E_DECAY;
  end

  // Per-voice next state: only the captured voice moves
  always_comb begin
    for (int unsigned v = 0; v < NV; v++) begin
      env_d[v] = env_q[v];
      est_d[v] = est_q[v];
      pg_d[v]  = pg_q[v];
      cnt_d[v] = cnt_q[v];
      if (upd_c && (idx_q == 2'(v))) begin
        env_d[v] = e_new;
        est_d[v] = s_new;
        pg_d[v]  = gate_q;
        cnt_d[v] = c_new;
      end
    end
  end

  // Capture, multiplier and result next state
  logic [AW-1:0] op_a_c;
  logic [EW-1:0] env_sel_c;

  always_comb begin
    env_sel_c = env_q[0];
    for (int unsigned v = 0; v < NV; v++) begin
      if (idx_q == 2'(v)) env_sel_c = env_q[v];
    end
    op_a_c = {{(AW-SW){smp_q[SW-1]}}, smp_q};
  end

  always_comb begin
    smp_d   = smp_q;
    idx_d   = idx_q;
    gate_d  = gate_q;
    atk_d   = atk_q;
    dec_d   = dec_q;
    sus_d   = sus_q;
    rel_d   = rel_q;
    ready_d = ready_q;
    prod_d  = prod_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    mcnt_d  = mcnt_q;
    if (accept_c) begin
      smp_d  = voice_i;
      idx_d  = voice_idx_i;
      gate_d = gate_i;
      atk_d  = attack_i;
      dec_d  = decay_i;
      sus_d  = sustain_i;
      rel_d  = release_i;
    end
    if (upd_c) ready_d = 1'b0;
    if (mload_c) begin
      ma_d   = {{(PW-AW){op_a_c[AW-1]}}, op_a_c};
      mb_d   = {8'h00, env_sel_c};
      acc_d  = '0;
      mcnt_d = '0;
    end
    if (mstep_c) begin
      if (mb_q[0]) acc_d = acc_q + ma_q;
      ma_d   = {ma_q[PW-2:0], 1'b0};
      mb_d   = {1'b0, mb_q[BW-1:1]};
      mcnt_d = mcnt_q + MCW'(1);
    end
    if (mdone_c) begin
      prod_d  = acc_q;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b1;
      prod_q  <= '0;
      smp_q   <= '0;
      idx_q   <= '0;
      gate_q  <= 1'b0;
      atk_q   <= '0;
      dec_q   <= '0;
      sus_q   <= '0;
      rel_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      mcnt_q  <= '0;
    end else begin
      ready_q <= ready_d;
      prod_q  <= prod_d;
      smp_q   <= smp_d;
      idx_q   <= idx_d;
      gate_q  <= gate_d;
      atk_q   <= atk_d;
      dec_q   <= dec_d;
      sus_q   <= sus_d;
      rel_q   <= rel_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned v = 0; v < NV; v++) begin
        env_q[v] <= '0;
        est_q[v] <= E_RELEASE;
        pg_q[v]  <= 1'b0;
        cnt_q[v] <= '0;
      end
    end else begin
      for (int unsigned v = 0; v < NV; v++) begin
        env_q[v] <= env_d[v];
        est_q[v] <= est_d[v];
        pg_q[v]  <= pg_d[v];
        cnt_q[v] <= cnt_d[v];
      end
    end
  end

  assign ready_o = ready_q;
  assign prod_o  = prod_q;

endmodule

// File: tb/tb_envelope_vca.sv
// Directed bench for envelope_vca: latency, ADSR trajectories, sign and voice independence.
module tb_envelope_vca;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [9:0]  voice_i = '0;
  logic [1:0]  voice_idx_i = '0;
  logic        gate_i = 1'b0;
  logic [3:0]  attack_i = '0, decay_i = '0, sustain_i = '0, release_i = '0;
  logic        ready_o;
  logic [39:0] prod_o;

  int total = 0;
  int bad = 0;

  int ptab [16] = '{1, 2, 3, 4, 6, 9, 11, 13, 16, 39, 78, 125, 156, 469, 781, 1250};
  int m_env [3];
  int m_st  [3];   // 0 release, 1 attack, 2 decay/sustain
  int m_pg  [3];
  int m_cnt [3];

  envelope_vca dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .voice_i(voice_i),
    .voice_idx_i(voice_idx_i), .gate_i(gate_i), .attack_i(attack_i),
    .decay_i(decay_i), .sustain_i(sustain_i), .release_i(release_i),
    .ready_o(ready_o), .prod_o(prod_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_env[i] = 0; m_st[i] = 0; m_pg[i] = 0; m_cnt[i] = 0;
    end
  endtask

  // Reference envelope: returns the level used for this tick's multiply
  task automatic model(input int idx, input logic g, input logic [3:0] a, d, s, r,
                       output int env);
    int per;
    if (g && m_pg[idx] == 0) begin m_st[idx] = 1; m_cnt[idx] = 0; end
    else if (!g && m_pg[idx] == 1) begin m_st[idx] = 0; m_cnt[idx] = 0; end
    m_pg[idx] = g ? 1 : 0;
    if (m_st[idx] == 1)      per = ptab[a];
    else if (m_st[idx] == 2) per = 3 * ptab[d];
    else                     per = 3 * ptab[r];
    if (m_cnt[idx] >= per - 1) begin
      m_cnt[idx] = 0;
      if (m_st[idx] == 1 && m_env[idx] < 255) m_env[idx]++;
      else if (m_st[idx] == 2 && m_env[idx] > 17 * int'(s)) m_env[idx]--;
      else if (m_st[idx] == 0 && m_env[idx] > 0) m_env[idx]--;
    end else begin
      m_cnt[idx]++;
    end
    if (m_st[idx] == 1 && m_env[idx] == 255) m_st[idx] = 2;
    env = m_env[idx];
  endtask

  // One sample tick; with lat set, start is held and voice_i disturbed during busy
  task automatic tick(input int idx, input logic [9:0] v, input logic g,
                      input logic [3:0] a, d, s, r, input bit lat);
    int env;
    longint p;
    @(negedge clk_i);
    voice_idx_i = 2'(idx); voice_i = v; gate_i = g;
    attack_i = a; decay_i = d; sustain_i = s; release_i = r;
    start_i = 1'b1;
    model(idx, g, a, d, s, r, env);
    p = longint'($signed(v)) * longint'(env);
    @(posedge clk_i);
    #1;
    if (!lat) start_i = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk_i);
      #1;
      if (lat && (i == 1 || i == 18)) chk("busy_ready", 40'(ready_o), 40'd0);
      if (lat && i == 5) voice_i = ~v;
    end
    start_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("ready_back", 40'(ready_o), 40'd1);
    chk("prod", prod_o, 40'(p));
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_ready", 40'(ready_o), 40'd1);
    chk("rst_prod", prod_o, 40'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Voice 0 idle tick with held start and latency probes
    tick(0, 10'd100, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    chk("v0_idle_prod", prod_o, 40'd0);

    // Voice index 3 is a no-op
    @(negedge clk_i);
    voice_idx_i = 2'd3; start_i = 1'b1; voice_i = 10'd77;
    @(posedge clk_i); #1;
    chk("noop_ready0", 40'(ready_o), 40'd1);
    @(posedge clk_i); #1;
    chk("noop_ready1", 40'(ready_o), 40'd1);
    chk("noop_prod", prod_o, 40'd0);
    start_i = 1'b0;

    // Attack to peak on voice 1
    for (int t = 1; t <= 255; t++) begin
      tick(1, 10'h1FF, 1'b1, 4'd0, 4'd0, 4'h8, 4'd1, 1'b0);
      if (t == 1)   chk("atk_tick1", prod_o, 40'd511);
      if (t == 255) chk("atk_tick255", prod_o, 40'd130305);
    end

    // Most negative sample at full envelope
    tick(1, 10'h200, 1'b1, 4'd0, 4'd0, 4'h8, 4'd1, 1'b0);
    chk("sign_peak", prod_o, 40'hFFFFFE0200);

    // Decay to sustain 0x88 and hold
    for (int t = 0; t < 400; t++) tick(1, 10'd1, 1'b1, 4'd0, 4'd0, 4'h8, 4'd1, 1'b0);
    chk("sustain_hold", prod_o, 40'd136);

    // Release at one step per 6 ticks
    for (int t = 0; t < 6; t++) tick(1, 10'd1, 1'b0, 4'd0, 4'd0, 4'h8, 4'd1, 1'b0);
    chk("release_first", prod_o, 40'd135);
    for (int t = 0; t < 830; t++) tick(1, 10'd1, 1'b0, 4'd0, 4'd0, 4'h8, 4'd1, 1'b0);
    chk("release_floor", prod_o, 40'd0);

    // Interleaved voices, then retrigger voice 2 mid-release
    for (int t = 0; t < 40; t++) begin
      tick(2, 10'd1, 1'b1, 4'd0, 4'd0, 4'h0, 4'd0, 1'b0);
      tick(0, 10'h3FD, 1'b1, 4'd3, 4'd1, 4'hC, 4'd2, 1'b0);
    end
    chk("v2_attack40", prod_o, prod_o);
    for (int t = 0; t < 12; t++) begin
      tick(2, 10'd1, 1'b0, 4'd0, 4'd0, 4'h0, 4'd0, 1'b0);
      tick(1, 10'd7, 1'b1, 4'd4, 4'd2, 4'h3, 4'd1, 1'b0);
    end
    tick(2, 10'd1, 1'b1, 4'd0, 4'd0, 4'h0, 4'd0, 1'b0);
    chk("retrigger", prod_o, 40'd37);
    for (int t = 0; t < 20; t++) begin
      tick(0, 10'h3FD, 1'b1, 4'd3, 4'd1, 4'hC, 4'd2, 1'b0);
      tick(1, 10'd7, 1'b0, 4'd4, 4'd2, 4'h3, 4'd1, 1'b0);
      tick(2, 10'h155, 1'b1, 4'd0, 4'd0, 4'h0, 4'd0, 1'b0);
    end

    // Reset in the middle of an operation
    @(negedge clk_i);
    voice_idx_i = 2'd0; voice_i = 10'd9; gate_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midrst_ready", 40'(ready_o), 40'd1);
    chk("midrst_prod", prod_o, 40'd0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick(0, 10'd9, 1'b1, 4'd0, 4'd0, 4'h0, 4'd0, 1'b0);
    chk("post_rst_env1", prod_o, 40'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
